inst_mem_loader: RTL and testbench
==================================

Name: inst_mem_loader

Overview:
- Writes the instruction memory. Receives a program image as a framed byte stream (16-bit word count, data bytes, XOR checksum) from a host link.
- Assembles bytes into width-bit words and issues one write per word at consecutive addresses from 0.
- Holds the CPU in reset while loading and flags completion or error.

Parameters:
- width, 32, instruction word width in bits; must be a multiple of 8 (BPW = width/8 bytes per word)
- depth, 2048, number of instruction memory words
- adr_in, 11, address width; depth <= 2^adr_in

Ports:
- clk  input  1  system clock
- rst  input  1  asynchronous active-low reset
- load_start  input  1  one-cycle pulse that begins a load; honoured only in IDLE, DONE or ERR
- byte_valid  input  1  byte_data holds a valid byte
- byte_data  input  8  stream byte
- byte_ready  output  1  loader can accept a byte this cycle
- wr_en  output  1  instruction memory write strobe, one cycle per word
- wr_adr  output  adr_in  word address for the write
- wr_data  output  width  assembled word
- cpu_hold  output  1  keeps the CPU in reset while high
- load_done  output  1  sticky; image loaded and checksum matched
- load_error  output  1  sticky; length overflow or checksum mismatch
- words_loaded  output  adr_in+1  count of words written in the current or last load

Behaviour:
- Reset (rst=0, async): state IDLE. All outputs are 0. Word counter, byte counter, shift register and checksum are cleared.
- Byte transfer: a byte is accepted on a rising edge with byte_valid=1 and byte_ready=1.
  - byte_ready=1 in LEN0, LEN1, DATA and CSUM.
  - byte_ready=0 in IDLE, WRITE, DONE and ERR.
  - The source must hold byte_data stable while byte_valid=1 and byte_ready=0.
- Checksum: running XOR of every accepted byte, including both length bytes and excluding the checksum byte.
- States:
  - IDLE: waits for load_start. On load_start: go to LEN0, set cpu_hold=1, clear load_done, load_error, words_loaded, checksum and counters.
  - LEN0: accepted byte becomes count[7:0].
  - LEN1: accepted byte becomes count[15:8]. On the next cycle, from the complete count:
    - count > depth -> ERR
    - count == 0 -> CSUM
    - otherwise -> DATA
  - DATA: bytes are assembled little-endian; the first byte goes to bits [7:0]. When the BPW-th byte is accepted, go to WRITE.
  - WRITE: exactly one cycle with wr_en=1, wr_adr=words_loaded[adr_in-1:0], wr_data=assembled word. words_loaded increments at the end of the cycle. If words_loaded+1 == count -> CSUM, else DATA.
  - CSUM: accepted byte is compared with the running XOR. Equal -> DONE; not equal -> ERR.
  - DONE: load_done=1, cpu_hold=0.
  - ERR: load_error=1, cpu_hold stays 1.
  - DONE and ERR persist until load_start (-> LEN0 with full clear) or reset.
- Timing:
  - Latency from acceptance of a word's last byte to its wr_en is one cycle.
  - Minimum interval between writes is BPW+1 cycles.
- wr_adr and wr_data are don't-care when wr_en=0; they hold their last value.
- load_start is ignored in LEN0, LEN1, DATA, WRITE and CSUM. A load cannot be restarted mid-stream except by reset.
- Reset mid-load: abort immediately. Writes already issued are not undone, and cpu_hold drops to 0.
- count == depth is legal. The last write uses address depth-1.

Test Plan:
- Nominal load: load_start, then bytes 02 00 13 00 00 00 EF BE AD DE 33 with byte_valid held -> wr_en at adr 0 data 0x00000013, then adr 1 data 0xDEADBEEF; load_done=1, cpu_hold=0, words_loaded=2, load_error=0.
- Bad checksum: same stream with last byte 0x34 -> both writes occur, load_error=1, load_done=0, cpu_hold=1, words_loaded=2.
- Zero length: bytes 00 00 00 -> no wr_en; load_done=1 in the cycle after the checksum byte is accepted.
- Overflow: bytes 01 08 (count 2049) -> ERR one cycle after the second byte, byte_ready=0, no wr_en, load_error=1; a later load_start plus a valid stream reaches DONE with load_error cleared.
- Backpressure: byte_valid held high continuously -> byte_ready low for exactly one cycle after each 4th data byte (the WRITE cycle); no byte is lost or duplicated, and write data matches.
- Reset mid-load: after 5 accepted bytes, assert rst=0 asynchronously -> all outputs 0 immediately; after release, a nominal load completes correctly. Also check that load_start during DATA has no effect.

Source files
------------

// File: rtl/inst_mem_loader.sv
// Instruction memory loader: parses a framed byte stream (length, data, XOR checksum),
// writes assembled words from address 0 and holds the CPU in reset until the image checks out.
module inst_mem_loader #(
  parameter int width  = 32,
  parameter int depth  = 2048,
  parameter int adr_in = 11
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_start,
  input  logic              byte_valid,
  input  logic [7:0]        byte_data,
  output logic              byte_ready,
  output logic              wr_en,
  output logic [adr_in-1:0] wr_adr,
  output logic [width-1:0]  wr_data,
  output logic              cpu_hold,
  output logic              load_done,
  output logic              load_error,
  output logic [adr_in:0]   words_loaded
);

  // state | meaning
  // IDLE  | waiting for load_start after reset
  // LEN0  | expecting count[7:0]
  // LEN1  | expecting count[15:8]; length checked as it is accepted
  // DATA  | assembling a word, little-endian
  // WRITE | single-cycle memory write of the assembled word
  // CSUM  | expecting checksum byte
  // DONE  | image valid, CPU released
  // ERR   | overflow or checksum mismatch, CPU held
  typedef enum logic [2:0] {IDLE, LEN0, LEN1, DATA, WRITE, CSUM, DONE, ERR} state_t;

  localparam int BPW = width / 8;
  localparam int BCW = (BPW > 1) ? $clog2(BPW) : 1;

  state_t             state;
  logic [15:0]        count;
  logic [BCW-1:0]     bcnt;
  logic [width-1:0]   shreg;
  logic [7:0]         csum;

  logic               accept;
  logic [width+7:0]   shift_tmp;
  logic [width-1:0]   next_word;
  logic [15:0]        full_count;
  logic [adr_in:0]    words_next;
  logic               last_word;

  assign accept     = byte_valid && byte_ready;
  // New byte enters at the top so that after BPW bytes the first one sits in [7:0].
  assign shift_tmp  = {byte_data, shreg};
  assign next_word  = shift_tmp[width+7:8];
  assign full_count = {byte_data, count[7:0]};
  assign words_next = words_loaded + 1'b1;
  assign last_word  = (32'(words_next) == 32'(count));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= IDLE;
      count        <= '0;
      bcnt         <= '0;
      shreg        <= '0;
      csum         <= '0;
      byte_ready   <= 1'b0;
      wr_en        <= 1'b0;
      wr_adr       <= '0;
      wr_data      <= '0;
      cpu_hold     <= 1'b0;
      load_done    <= 1'b0;
      load_error   <= 1'b0;
      words_loaded <= '0;
    end else begin
      wr_en <= 1'b0;
      case (state)
        IDLE, DONE, ERR: begin
          if (load_start) begin
            state        <= LEN0;
            byte_ready   <= 1'b1;
            cpu_hold     <= 1'b1;
            load_done    <= 1'b0;
            load_error   <= 1'b0;
            words_loaded <= '0;
            csum         <= '0;
            count        <= '0;
            bcnt         <= '0;
            shreg        <= '0;
          end
        end
        LEN0: begin
          if (accept) begin
            count[7:0] <= byte_data;
            csum       <= csum ^ byte_data;
            state      <= LEN1;
          end
        end
        LEN1: begin
          if (accept) begin
            count[15:8] <= byte_data;
            csum        <= csum ^ byte_data;
            if (32'(full_count) > depth) begin
              state      <= ERR;
              byte_ready <= 1'b0;
              load_error <= 1'b1;
            end else if (full_count == 16'd0) begin
              state <= CSUM;
            end else begin
              state <= DATA;
            end
          end
        end
        DATA: begin
          if (accept) begin
            csum  <= csum ^ byte_data;
            shreg <= next_word;
            if (bcnt == BCW'(BPW - 1)) begin
              bcnt       <= '0;
              state      <= WRITE;
              byte_ready <= 1'b0;
              wr_en      <= 1'b1;
              wr_adr     <= words_loaded[adr_in-1:0];
              wr_data    <= next_word;
            end else begin
              bcnt <= bcnt + 1'b1;
            end
          end
        end
        WRITE: begin
          words_loaded <= words_next;
          byte_ready   <= 1'b1;
          state        <= last_word ? CSUM : DATA;
        end
        CSUM: begin
          if (accept) begin
            byte_ready <= 1'b0;
            if (byte_data == csum) begin
              state     <= DONE;
              load_done <= 1'b1;
              cpu_hold  <= 1'b0;
            end else begin
              state      <= ERR;
              load_error <= 1'b1;
            end
          end
        end
        default: begin
          state      <= IDLE;
          byte_ready <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_inst_mem_loader.sv
// Randomised self-checking bench for inst_mem_loader; expected results come from
// decoding each frame with plain arithmetic over the byte list.
module tb_inst_mem_loader;
  localparam int W   = 32;
  localparam int D   = 2048;
  localparam int A   = 11;
  localparam int BPW = W / 8;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         load_start = 1'b0;
  logic         byte_valid = 1'b0;
  logic [7:0]   byte_data = 8'h00;
  logic         byte_ready, wr_en, cpu_hold, load_done, load_error;
  logic [A-1:0] wr_adr;
  logic [W-1:0] wr_data;
  logic [A:0]   words_loaded;

  inst_mem_loader #(.width(W), .depth(D), .adr_in(A)) dut (
    .clk(clk), .rst(rst), .load_start(load_start), .byte_valid(byte_valid),
    .byte_data(byte_data), .byte_ready(byte_ready), .wr_en(wr_en), .wr_adr(wr_adr),
    .wr_data(wr_data), .cpu_hold(cpu_hold), .load_done(load_done),
    .load_error(load_error), .words_loaded(words_loaded)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int stalls = 0;
  logic [7:0]   frame[$];
  logic [A-1:0] got_adr[$];
  logic [W-1:0] got_data[$];
  int           got_cyc[$];

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (rst && wr_en) begin
      got_adr.push_back(wr_adr);
      got_data.push_back(wr_data);
      got_cyc.push_back(cyc);
    end
  end

  task automatic send_byte(input logic [7:0] b);
    int tries = 0;
    byte_valid = 1'b1;
    byte_data  = b;
    while (!byte_ready && tries < 100) begin
      @(negedge clk);
      tries++;
    end
    stalls += tries;
    checks++;
    if (!byte_ready) begin
      failures++;
      $display("FAIL byte_accept_timeout: byte_ready=%0b after %0d cycles, required 1", byte_ready, tries);
    end
    @(negedge clk);
  endtask

  task automatic start_load();
    @(negedge clk);
    load_start = 1'b1;
    @(negedge clk);
    load_start = 1'b0;
  endtask

  task automatic run_frame(input int gap_max, input int pulse_at);
    got_adr.delete();
    got_data.delete();
    got_cyc.delete();
    stalls = 0;
    start_load();
    for (int i = 0; i < frame.size(); i++) begin
      if (i == pulse_at) begin
        byte_valid = 1'b0;
        load_start = 1'b1;
        @(negedge clk);
        load_start = 1'b0;
      end
      if (gap_max > 0) begin
        byte_valid = 1'b0;
        repeat ($urandom_range(0, gap_max)) @(negedge clk);
      end
      send_byte(frame[i]);
    end
    byte_valid = 1'b0;
  endtask

  task automatic make_frame(input int cnt, input bit bad);
    logic [31:0] w;
    logic [7:0]  x;
    frame.delete();
    frame.push_back(cnt[7:0]);
    frame.push_back(cnt[15:8]);
    for (int i = 0; i < cnt; i++) begin
      w = $urandom;
      for (int b = 0; b < BPW; b++) frame.push_back(w[8*b +: 8]);
    end
    x = 8'h00;
    foreach (frame[i]) x ^= frame[i];
    frame.push_back(bad ? (x ^ 8'h5A) : x);
  endtask

  // Decodes the frame from first principles and compares everything observable.
  task automatic check_frame(input string name, input bit timing);
    int          cnt, nexp, nchk;
    bit          exp_done;
    logic [7:0]  x;
    logic [W-1:0] w;
    cnt = int'({frame[1], frame[0]});
    if (cnt > D) begin
      exp_done = 1'b0;
      nexp = 0;
    end else begin
      x = 8'h00;
      for (int i = 0; i < 2 + cnt * BPW; i++) x ^= frame[i];
      exp_done = (x == frame[2 + cnt * BPW]);
      nexp = cnt;
    end
    checks++;
    if (load_done !== exp_done) begin
      failures++; $display("FAIL %s load_done: got %0b want %0b", name, load_done, exp_done);
    end
    checks++;
    if (load_error !== !exp_done) begin
      failures++; $display("FAIL %s load_error: got %0b want %0b", name, load_error, !exp_done);
    end
    checks++;
    if (cpu_hold !== !exp_done) begin
      failures++; $display("FAIL %s cpu_hold: got %0b want %0b", name, cpu_hold, !exp_done);
    end
    checks++;
    if (byte_ready !== 1'b0) begin
      failures++; $display("FAIL %s byte_ready: got %0b want 0", name, byte_ready);
    end
    checks++;
    if (int'(words_loaded) != nexp) begin
      failures++; $display("FAIL %s words_loaded: got %0d want %0d", name, words_loaded, nexp);
    end
    checks++;
    if (got_adr.size() != nexp) begin
      failures++; $display("FAIL %s write_count: got %0d want %0d", name, got_adr.size(), nexp);
    end
    nchk = (got_adr.size() < nexp) ? got_adr.size() : nexp;
    for (int i = 0; i < nchk; i++) begin
      for (int b = 0; b < BPW; b++) w[8*b +: 8] = frame[2 + i * BPW + b];
      checks++;
      if (int'(got_adr[i]) != i) begin
        failures++; $display("FAIL %s wr_adr[%0d]: got %0d want %0d", name, i, got_adr[i], i);
      end
      checks++;
      if (got_data[i] !== w) begin
        failures++; $display("FAIL %s wr_data[%0d]: got %h want %h", name, i, got_data[i], w);
      end
      if (timing && i > 0) begin
        checks++;
        if (got_cyc[i] - got_cyc[i-1] != BPW + 1) begin
          failures++;
          $display("FAIL %s write_interval[%0d]: got %0d want %0d", name, i, got_cyc[i] - got_cyc[i-1], BPW + 1);
        end
      end
    end
    if (timing && cnt <= D) begin
      checks++;
      if (stalls != cnt) begin
        failures++; $display("FAIL %s stall_cycles: got %0d want %0d", name, stalls, cnt);
      end
    end
  endtask

  task automatic load_nominal();
    frame.delete();
    foreach (nominal_bytes[i]) frame.push_back(nominal_bytes[i]);
  endtask

  logic [7:0] nominal_bytes [11] = '{8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00,
                                     8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'h33};

  task automatic test_reset();
    #2 rst = 1'b0;
    #1;
    checks++;
    if ({byte_ready, wr_en, wr_adr, wr_data, cpu_hold, load_done, load_error, words_loaded} !== '0) begin
      failures++; $display("FAIL reset_outputs: byte_ready=%0b wr_en=%0b cpu_hold=%0b done=%0b err=%0b words=%0d want all 0",
                           byte_ready, wr_en, cpu_hold, load_done, load_error, words_loaded);
    end
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (byte_ready !== 1'b0 || cpu_hold !== 1'b0) begin
      failures++; $display("FAIL idle_after_reset: byte_ready=%0b cpu_hold=%0b want 0 0", byte_ready, cpu_hold);
    end
  endtask

  task automatic test_nominal();
    load_nominal();
    run_frame(0, -1);
    check_frame("nominal", 1'b1);
    checks++;
    if (got_data.size() != 2 || got_data[0] !== 32'h0000_0013 || got_data[1] !== 32'hDEAD_BEEF) begin
      failures++; $display("FAIL nominal_words: got %0d writes, want 00000013 DEADBEEF", got_data.size());
    end
  endtask

  task automatic test_bad_checksum();
    load_nominal();
    frame[10] = 8'h34;
    run_frame(0, -1);
    check_frame("bad_csum", 1'b1);
  endtask

  task automatic test_zero_length();
    frame = '{8'h00, 8'h00, 8'h00};
    run_frame(0, -1);
    check_frame("zero_len", 1'b1);
  endtask

  task automatic test_overflow();
    frame = '{8'h01, 8'h08};
    run_frame(0, -1);
    check_frame("overflow", 1'b0);
    load_nominal();
    run_frame(0, -1);
    check_frame("after_overflow", 1'b1);
  endtask

  task automatic test_full_depth();
    make_frame(D, 1'b0);
    run_frame(0, -1);
    check_frame("full_depth", 1'b1);
    checks++;
    if (got_adr.size() == 0 || int'(got_adr[got_adr.size()-1]) != D - 1) begin
      failures++; $display("FAIL full_depth_last_adr: writes=%0d want last adr %0d", got_adr.size(), D - 1);
    end
  endtask

  task automatic test_reset_mid_load();
    start_load();
    for (int i = 0; i < 5; i++) send_byte(nominal_bytes[i]);
    byte_valid = 1'b0;
    #2 rst = 1'b0;
    #1;
    checks++;
    if ({byte_ready, wr_en, wr_adr, wr_data, cpu_hold, load_done, load_error, words_loaded} !== '0) begin
      failures++; $display("FAIL mid_reset_outputs: byte_ready=%0b cpu_hold=%0b done=%0b err=%0b words=%0d want all 0",
                           byte_ready, cpu_hold, load_done, load_error, words_loaded);
    end
    @(negedge clk);
    rst = 1'b1;
    load_nominal();
    run_frame(0, -1);
    check_frame("after_mid_reset", 1'b1);
  endtask

  task automatic test_start_ignored();
    make_frame(3, 1'b0);
    run_frame(0, 5);
    check_frame("start_in_data", 1'b0);
  endtask

  task automatic test_random();
    for (int k = 0; k < 8; k++) begin
      int gap;
      gap = $urandom_range(0, 2);
      make_frame($urandom_range(1, 8), ($urandom_range(0, 3) == 0));
      run_frame(gap, -1);
      check_frame($sformatf("random%0d", k), gap == 0);
    end
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_bad_checksum();
    test_zero_length();
    test_overflow();
    test_start_ignored();
    test_reset_mid_load();
    test_random();
    test_full_depth();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
